dk_input_ctrl: RTL and testbench
================================

Name: dk_input_ctrl

Overview:
- Input conditioning stage directly upstream of dkong_top.
- Merges PS/2 key events and the two ORed MiSTer joystick words into DK control lines. Applies orientation remapping and suppresses opposing directions.
- Sequences a timed coin pulse followed by a timed start pulse, so that one Start press credits and starts a game.
- All outputs are active-low and registered, and connect straight to dkong_top I_U1..I_C1.

Parameters:
COIN_PULSE_CYC, 2457600, low time of the O_C1 and O_S1/O_S2 pulses in clock cycles (100 ms at 24.576 MHz).
START_DELAY_CYC, 4915200, cycles between the end of the coin pulse and the start of the start pulse (200 ms).

Ports:
I_CLK_24576M  in  1  system clock, 24.576 MHz
I_RESETn  in  1  asynchronous active-low reset
I_PS2_KEY  in  11  [10] toggles once per event, [9] pressed, [8] extended, [7:0] scan code
I_JOY  in  16  joystick_0|joystick_1; [0]R [1]L [2]D [3]U [4]jump [5]start1 [6]start2
I_ROTATE  in  1  1 = horizontal orientation, remap directions
O_U, O_D, O_L, O_R  out  1  directions, active-low
O_J  out  1  jump, active-low
O_S1, O_S2  out  1  start 1P/2P pulses, active-low
O_C1  out  1  coin pulse, active-low

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs are 1.
  - Key-state registers are 0, the FSM is IDLE and counters are 0.
  - The event-seen flag is cleared.
- PS/2 event detection:
  - In the first cycle after reset, the module captures I_PS2_KEY[10] into a previous-toggle register and sets the event-seen flag. No event is generated in that cycle.
  - After that, any difference between I_PS2_KEY[10] and the previous-toggle register is one event.
- Key decode:
  - Arrow keys ignore bit 8: scan codes 0x75 up, 0x72 down, 0x6B left, 0x74 right.
  - The following codes are non-extended only: 0x029 space, 0x014 ctrl, 0x005 F1, 0x006 F2.
  - Each key has its own state register, loaded with bit 9 on its event. Other codes are ignored.
  - Key fire = space | ctrl. Releasing one of the two keys does not clear fire while the other is held.
- Combine:
  - rU = keyU|I_JOY[3], rD = keyD|I_JOY[2], rL = keyL|I_JOY[1], rR = keyR|I_JOY[0].
  - With I_ROTATE=1: up = rL, down = rR, left = rD, right = rU. With I_ROTATE=0: identity mapping.
- Opposing directions:
  - If up and down are both active after remapping, neither is driven; the same rule applies to left and right.
  - O_U/O_D/O_L/O_R/O_J = inverted result, registered, with 1-cycle latency from the combined inputs.
- Start requests:
  - s1 = F1|I_JOY[5], s2 = F2|I_JOY[6].
  - Rising edges are detected against the previous-cycle value, which is 0 after reset.
- FSM:
  - IDLE: on a rising edge of s1 or s2, latch sel (s1 wins if both rise in the same cycle), clear the counter and go to COIN.
  - COIN: O_C1=0 for exactly COIN_PULSE_CYC cycles, then go to GAP.
  - GAP: all start and coin outputs are 1 for START_DELAY_CYC cycles, then go to START.
  - START: the selected O_S1 or O_S2 is 0 for COIN_PULSE_CYC cycles, then go to WAITREL.
  - WAITREL: stay until s1=0 and s2=0, then go to IDLE.
  - Edges that occur outside IDLE are ignored and not queued.
  - O_C1/O_S1/O_S2 are registered. The first low cycle of O_C1 is the cycle after the edge.
  - The counter is the minimal width that holds max(COIN_PULSE_CYC, START_DELAY_CYC). It does not wrap: it is cleared on every state change.
- Reset mid-sequence: the FSM returns to IDLE and pulses end immediately. A start input still held at reset release does not retrigger until it is released and pressed again.

Test Plan:
- Reset release with I_PS2_KEY[10]=1 and no toggle -> no key state set; all outputs stay 1 for 100 cycles.
- Toggle with {ext=1,pressed=1,0x75} -> O_U=0 two cycles after the toggle. Toggle with pressed=0 -> O_U returns to 1. Repeat with I_ROTATE=1: key 0x6B (left) -> O_U=0.
- I_JOY[3] and I_JOY[2] both =1 -> O_U=1 and O_D=1. Drop I_JOY[2] -> O_U=0 the next cycle.
- Press space, then press ctrl, then release space -> O_J stays 0. Release ctrl -> O_J=1.
- COIN_PULSE_CYC=4, START_DELAY_CYC=6: pulse I_JOY[6] for 1 cycle -> O_C1 low for exactly 4 cycles, then 6 cycles with all lines high, then O_S2 low for 4 cycles. O_S1 stays 1 throughout. A second I_JOY[6] pulse during GAP causes no extra pulses.
- Hold I_JOY[5] through the whole sequence -> the FSM stays in WAITREL and issues no retrigger. Assert I_RESETn=0 during COIN -> O_C1=1 within the same cycle (asynchronous).

Source files
------------

// File: rtl/dk_input_ctrl.sv
// rtl/dk_input_ctrl.sv - PS/2 + joystick input conditioning with coin/start sequencer for dkong_top
module dk_input_ctrl #(
   parameter int COIN_PULSE_CYC  = 2457600,
   parameter int START_DELAY_CYC = 4915200
) (
   input  logic        I_CLK_24576M,
   input  logic        I_RESETn,
   input  logic [10:0] I_PS2_KEY,
   input  logic [15:0] I_JOY,
   input  logic        I_ROTATE,
   output logic        O_U,
   output logic        O_D,
   output logic        O_L,
   output logic        O_R,
   output logic        O_J,
   output logic        O_S1,
   output logic        O_S2,
   output logic        O_C1
);

   localparam int MAX_CYC = (COIN_PULSE_CYC > START_DELAY_CYC) ? COIN_PULSE_CYC : START_DELAY_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] COIN_LAST  = CW'(COIN_PULSE_CYC - 1);
   localparam logic [CW-1:0] DELAY_LAST = CW'(START_DELAY_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_COIN, S_GAP, S_START, S_WAITREL} state_t;

   logic [1:0]    r_rst_sync;
   logic          w_rst_n;
   logic          r_seen;
   logic          r_prev_tog;
   logic          r_key_u, r_key_d, r_key_l, r_key_r;
   logic          r_key_space, r_key_ctrl, r_key_f1, r_key_f2;
   logic          r_u, r_d, r_l, r_r, r_j;
   logic          r_s1_prev, r_s2_prev;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_sel_s2;
   logic          r_c1, r_s1o, r_s2o;

   logic w_event, w_ext, w_press;
   logic [7:0] w_code;
   logic w_ru, w_rd, w_rl, w_rr;
   logic w_up, w_dn, w_lf, w_rt, w_fire;
   logic w_s1, w_s2, w_s1_rise, w_s2_rise;
   logic w_unused;

   assign w_unused = &{1'b0, I_JOY[15:7]};

   // Reset is taken asynchronously but released in step with the clock
   always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
      if (!I_RESETn) r_rst_sync <= 2'b00;
      else           r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_code  = I_PS2_KEY[7:0];
   assign w_ext   = I_PS2_KEY[8];
   assign w_press = I_PS2_KEY[9];
   assign w_event = r_seen & (I_PS2_KEY[10] ^ r_prev_tog);

   // Track the PS/2 toggle bit; the first post-reset cycle only primes the history
   always_ff @(posedge I_CLK_24576M or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_seen     <= 1'b0;
         r_prev_tog <= 1'b0;
      end else begin
         r_seen     <= 1'b1;
         r_prev_tog <= I_PS2_KEY[10];
      end
   end

   // Per-key held state, updated on each PS/2 event for a recognised code
   always_ff @(posedge I_CLK_24576M or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_key_u     <= 1'b0;
         r_key_d     <= 1'b0;
         r_key_l     <= 1'b0;
         r_key_r     <= 1'b0;
         r_key_space <= 1'b0;
         r_key_ctrl  <= 1'b0;
         r_key_f1    <= 1'b0;
         r_key_f2    <= 1'b0;
      end else if (w_event) begin
         case (w_code)
            8'h75: r_key_u <= w_press;
            8'h72: r_key_d <= w_press;
            8'h6B: r_key_l <= w_press;
            8'h74: r_key_r <= w_press;
            8'h29: if (!w_ext) r_key_space <= w_press;
            8'h14: if (!w_ext) r_key_ctrl  <= w_press;
            8'h05: if (!w_ext) r_key_f1    <= w_press;
            8'h06: if (!w_ext) r_key_f2    <= w_press;
            default: ;
         endcase
      end
   end

   assign w_ru   = r_key_u | I_JOY[3];
   assign w_rd   = r_key_d | I_JOY[2];
   assign w_rl   = r_key_l | I_JOY[1];
   assign w_rr   = r_key_r | I_JOY[0];
   assign w_up   = I_ROTATE ? w_rl : w_ru;
   assign w_dn   = I_ROTATE ? w_rr : w_rd;
   assign w_lf   = I_ROTATE ? w_rd : w_rl;
   assign w_rt   = I_ROTATE ? w_ru : w_rr;
   assign w_fire = r_key_space | r_key_ctrl | I_JOY[4];

   // Register active-low controls, dropping both of an opposing pair
   always_ff @(posedge I_CLK_24576M or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_u <= 1'b1;
         r_d <= 1'b1;
         r_l <= 1'b1;
         r_r <= 1'b1;
         r_j <= 1'b1;
      end else begin
         r_u <= ~(w_up & ~w_dn);
         r_d <= ~(w_dn & ~w_up);
         r_l <= ~(w_lf & ~w_rt);
         r_r <= ~(w_rt & ~w_lf);
         r_j <= ~w_fire;
      end
   end

   assign w_s1 = r_key_f1 | I_JOY[5];
   assign w_s2 = r_key_f2 | I_JOY[6];
   // Edges are masked in the priming cycle so a start held through reset cannot retrigger
   assign w_s1_rise = r_seen & w_s1 & ~r_s1_prev;
   assign w_s2_rise = r_seen & w_s2 & ~r_s2_prev;

   // Previous-cycle start request levels for edge detection
   always_ff @(posedge I_CLK_24576M or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_s1_prev <= 1'b0;
         r_s2_prev <= 1'b0;
      end else begin
         r_s1_prev <= w_s1;
         r_s2_prev <= w_s2;
      end
   end

   // Coin -> gap -> start sequencer with registered active-low pulses
   always_ff @(posedge I_CLK_24576M or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_sel_s2 <= 1'b0;
         r_c1     <= 1'b1;
         r_s1o    <= 1'b1;
         r_s2o    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_s1_rise || w_s2_rise) begin
                  r_sel_s2 <= ~w_s1_rise;
                  r_cnt    <= '0;
                  r_c1     <= 1'b0;
                  r_state  <= S_COIN;
               end
            end
            S_COIN: begin
               if (r_cnt == COIN_LAST) begin
                  r_cnt   <= '0;
                  r_c1    <= 1'b1;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_cnt == DELAY_LAST) begin
                  r_cnt   <= '0;
                  r_s1o   <= r_sel_s2;
                  r_s2o   <= ~r_sel_s2;
                  r_state <= S_START;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_START: begin
               if (r_cnt == COIN_LAST) begin
                  r_cnt   <= '0;
                  r_s1o   <= 1'b1;
                  r_s2o   <= 1'b1;
                  r_state <= S_WAITREL;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAITREL: begin
               if (!w_s1 && !w_s2) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_c1    <= 1'b1;
               r_s1o   <= 1'b1;
               r_s2o   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign O_U  = r_u;
   assign O_D  = r_d;
   assign O_L  = r_l;
   assign O_R  = r_r;
   assign O_J  = r_j;
   assign O_S1 = r_s1o;
   assign O_S2 = r_s2o;
   assign O_C1 = r_c1;

endmodule

// File: tb/tb_dk_input_ctrl.sv
// tb/tb_dk_input_ctrl.sv - directed self-checking bench for dk_input_ctrl
module tb_dk_input_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] ps2;
   logic [15:0] joy;
   logic        rot;
   logic        o_u, o_d, o_l, o_r, o_j, o_s1, o_s2, o_c1;
   int          errors = 0;
   int          checks = 0;
   int          bad, c1_low, s1_low, s2_low;

   always #5 clk = ~clk;

   dk_input_ctrl #(.COIN_PULSE_CYC(4), .START_DELAY_CYC(6)) u_dut (
      .I_CLK_24576M (clk),
      .I_RESETn     (rst_n),
      .I_PS2_KEY    (ps2),
      .I_JOY        (joy),
      .I_ROTATE     (rot),
      .O_U          (o_u),
      .O_D          (o_d),
      .O_L          (o_l),
      .O_R          (o_r),
      .O_J          (o_j),
      .O_S1         (o_s1),
      .O_S2         (o_s2),
      .O_C1         (o_c1)
   );

   wire [7:0] outs = {o_u, o_d, o_l, o_r, o_j, o_s1, o_s2, o_c1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic key(input logic ext, input logic pr, input logic [7:0] code);
      ps2 = {~ps2[10], pr, ext, code};
      step();
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      ps2   = 11'h400;
      joy   = 16'h0000;
      rot   = 1'b0;
      repeat (3) step();
      chk("reset_outs", int'(outs), 8'hFF);

      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (outs !== 8'hFF) bad++;
         step();
      end
      chk("idle_100_all_high", bad, 0);

      ps2 = {~ps2[10], 1'b1, 1'b1, 8'h75};
      step();
      chk("up_latency_cyc1", int'(o_u), 1);
      step();
      chk("up_press_cyc2", int'(o_u), 0);
      key(1'b1, 1'b0, 8'h75);
      chk("up_release", int'(o_u), 1);
      key(1'b0, 1'b1, 8'h75);
      chk("up_nonext_press", int'(o_u), 0);
      key(1'b0, 1'b0, 8'h75);

      rot = 1'b1;
      key(1'b1, 1'b1, 8'h6B);
      chk("rot_left_to_up", int'(o_u), 0);
      chk("rot_left_not_left", int'(o_l), 1);
      key(1'b1, 1'b0, 8'h6B);
      rot = 1'b0;
      step();
      chk("rot_release", int'(outs), 8'hFF);

      joy = 16'h000C;
      step();
      chk("opp_ud_up", int'(o_u), 1);
      chk("opp_ud_down", int'(o_d), 1);
      joy = 16'h0008;
      step();
      chk("drop_down_up_on", int'(o_u), 0);
      joy = 16'h0003;
      step();
      chk("opp_lr", int'({o_l, o_r}), 2'b11);
      joy = 16'h0000;
      step();

      key(1'b0, 1'b1, 8'h29);
      chk("space_fire", int'(o_j), 0);
      key(1'b0, 1'b1, 8'h14);
      key(1'b0, 1'b0, 8'h29);
      chk("ctrl_holds_fire", int'(o_j), 0);
      key(1'b0, 1'b0, 8'h14);
      chk("fire_released", int'(o_j), 1);
      key(1'b1, 1'b1, 8'h29);
      chk("ext_space_ignored", int'(o_j), 1);
      key(1'b1, 1'b0, 8'h29);

      joy[6] = 1'b1;
      step();
      joy[6] = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (o_c1 !== 1'b0 || o_s1 !== 1'b1 || o_s2 !== 1'b1) bad++;
         step();
      end
      chk("coin_low_4", bad, 0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (outs !== 8'hFF) bad++;
         if (i == 2) joy[6] = 1'b1;
         if (i == 3) joy[6] = 1'b0;
         step();
      end
      chk("gap_high_6", bad, 0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (o_s2 !== 1'b0 || o_s1 !== 1'b1 || o_c1 !== 1'b1) bad++;
         step();
      end
      chk("start2_low_4", bad, 0);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (outs !== 8'hFF) bad++;
         step();
      end
      chk("no_queued_retrigger", bad, 0);

      joy[5] = 1'b1;
      step();
      c1_low = 0;
      s1_low = 0;
      s2_low = 0;
      for (int i = 0; i < 44; i++) begin
         if (o_c1 === 1'b0) c1_low++;
         if (o_s1 === 1'b0) s1_low++;
         if (o_s2 === 1'b0) s2_low++;
         step();
      end
      chk("held_s1_coin_cycles", c1_low, 4);
      chk("held_s1_start_cycles", s1_low, 4);
      chk("held_s1_no_s2", s2_low, 0);

      joy[5] = 1'b0;
      step();
      step();
      joy[5] = 1'b1;
      step();
      chk("second_coin_start", int'(o_c1), 0);
      step();
      chk("second_coin_mid", int'(o_c1), 0);
      rst_n = 1'b0;
      #1;
      chk("async_reset_ends_coin", int'(o_c1), 1);
      step();
      rst_n = 1'b1;
      c1_low = 0;
      s1_low = 0;
      for (int i = 0; i < 40; i++) begin
         if (o_c1 === 1'b0) c1_low++;
         if (o_s1 === 1'b0) s1_low++;
         step();
      end
      chk("held_through_reset_no_coin", c1_low, 0);
      chk("held_through_reset_no_start", s1_low, 0);
      joy = 16'h0000;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
